bus_gate_array: RTL and testbench

Parametrised multi-source bus gate for the LC-3b datapath bus. It generalises the single-source tristate gate to CHANNELS sources of WIDTH bits, with priority resolution and drive-conflict detection. An optional bus-keeper mode holds the last driven value when no source is gated. It sits between the datapath source registers (MDR, PC, ALU, MARMUX, …) and the shared bus, and gives the control FSM visibility of illegal multi-drive cycles.

---
 rtl/bus_gate_array.sv | 58 +++++
 tb/tb_bus_gate_array.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bus_gate_array.sv
// bus_gate_array: priority-resolved multi-source bus gate with conflict tracking and optional keeper
module bus_gate_array #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter bit KEEPER = 1'b0,
  localparam int OW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS*WIDTH-1:0] in_i,
  input  logic                      clear_err_i,
  output logic [WIDTH-1:0]          out_o,
  output logic                      driving_o,
  output logic [OW-1:0]             last_owner_o,
  output logic                      conflict_o,
  output logic [7:0]                conflict_count_o
);
  logic [OW-1:0]    win_idx, owner_d, owner_q;
  logic [WIDTH-1:0] win_dat, keeper_d, keeper_q;
  logic             multi, conflict_d, conflict_q;
  logic [7:0]       count_d, count_q;
  always_comb begin
    win_idx = '0;
    win_dat = '0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (enable_i[k]) begin
        win_idx = OW'(k);
        win_dat = in_i[k*WIDTH +: WIDTH];
      end
  end
  assign driving_o = |enable_i;
  // clearing the lowest set bit leaves something only if two or more were set
  assign multi = |(enable_i & (enable_i - CHANNELS'(1)));
  assign out_o = driving_o ? win_dat : (KEEPER ? keeper_q : {WIDTH{1'bz}});
  always_comb begin
    conflict_d = clear_err_i ? multi : (conflict_q | multi);
    count_d    = clear_err_i ? {7'd0, multi} :
                 (multi && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    owner_d    = driving_o ? win_idx : owner_q;
    keeper_d   = driving_o ? win_dat : keeper_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      keeper_q   <= '0;
      owner_q    <= '0;
      conflict_q <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      keeper_q   <= keeper_d;
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  assign last_owner_o     = owner_q;
  assign conflict_o       = conflict_q;
  assign conflict_count_o = count_q;
endmodule

// File: tb/tb_bus_gate_array.sv
// tb_bus_gate_array: directed checks of floating and keeper variants sharing one stimulus
module tb_bus_gate_array;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  enable;
  logic [63:0] in_v;
  logic        clear_err;
  logic [15:0] out0, out1;
  logic        drv0, drv1, cf0, cf1;
  logic [1:0]  own0, own1;
  logic [7:0]  cnt0, cnt1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_gate_array #(.WIDTH(16), .CHANNELS(4), .KEEPER(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .in_i(in_v), .clear_err_i(clear_err),
    .out_o(out0), .driving_o(drv0), .last_owner_o(own0), .conflict_o(cf0), .conflict_count_o(cnt0));
  bus_gate_array #(.WIDTH(16), .CHANNELS(4), .KEEPER(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .in_i(in_v), .clear_err_i(clear_err),
    .out_o(out1), .driving_o(drv1), .last_owner_o(own1), .conflict_o(cf1), .conflict_count_o(cnt1));

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 4'b0000; in_v = '0; clear_err = 1'b0;
    #2;
    checks++; if (out1 !== 16'h0000) begin failures++; $display("FAIL reset_out1 got=%h exp=0000", out1); end
    checks++; if (drv0 !== 1'b0) begin failures++; $display("FAIL reset_driving got=%b exp=0", drv0); end
    checks++; if (own1 !== 2'd0 || cf1 !== 1'b0 || cnt1 !== 8'd0) begin failures++; $display("FAIL reset_regs got=%0d/%b/%0d exp=0/0/0", own1, cf1, cnt1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_drive();
    @(negedge clk);
    enable = 4'b0100; in_v[32 +: 16] = 16'h3C5A;
    #1;
    checks++; if (out0 !== 16'h3C5A || drv0 !== 1'b1) begin failures++; $display("FAIL single_comb got=%h/%b exp=3c5a/1", out0, drv0); end
    checks++; if (own0 !== 2'd0) begin failures++; $display("FAIL single_owner_early got=%0d exp=0", own0); end
    edge_sample();
    checks++; if (own0 !== 2'd2 || cf0 !== 1'b0) begin failures++; $display("FAIL single_owner got=%0d/%b exp=2/0", own0, cf0); end
    @(negedge clk); enable = 4'b0000;
    #1;
    checks++; if (drv0 !== 1'b0) begin failures++; $display("FAIL idle_driving got=%b exp=0", drv0); end
    checks++; if (out1 !== 16'h3C5A) begin failures++; $display("FAIL idle_keeper got=%h exp=3c5a", out1); end
  endtask

  task automatic test_keeper();
    @(negedge clk);
    enable = 4'b0010; in_v[16 +: 16] = 16'hBEEF;
    @(negedge clk); enable = 4'b0000; in_v = '0;
    repeat (3) edge_sample();
    checks++; if (out1 !== 16'hBEEF || own1 !== 2'd1) begin failures++; $display("FAIL keeper_hold got=%h/%0d exp=beef/1", out1, own1); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (out1 !== 16'h0000 || own1 !== 2'd0) begin failures++; $display("FAIL keeper_async_rst got=%h/%0d exp=0000/0", out1, own1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_priority_conflict();
    @(negedge clk);
    enable = 4'b1010; in_v[16 +: 16] = 16'h1111; in_v[48 +: 16] = 16'h3333;
    #1;
    checks++; if (out0 !== 16'h1111 || out1 !== 16'h1111) begin failures++; $display("FAIL prio_out got=%h/%h exp=1111", out0, out1); end
    edge_sample();
    checks++; if (cf1 !== 1'b1 || cnt1 !== 8'd1 || own1 !== 2'd1) begin failures++; $display("FAIL prio_edge got=%b/%0d/%0d exp=1/1/1", cf1, cnt1, own1); end
    repeat (3) edge_sample();
    checks++; if (cnt0 !== 8'd4) begin failures++; $display("FAIL prio_count4 got=%0d exp=4", cnt0); end
  endtask

  task automatic test_clear();
    @(negedge clk); clear_err = 1'b1; enable = 4'b0001;
    edge_sample();
    checks++; if (cf1 !== 1'b0 || cnt1 !== 8'd0 || own1 !== 2'd0) begin failures++; $display("FAIL clear_single got=%b/%0d/%0d exp=0/0/0", cf1, cnt1, own1); end
    @(negedge clk); enable = 4'b0011;
    edge_sample();
    checks++; if (cf1 !== 1'b1 || cnt1 !== 8'd1) begin failures++; $display("FAIL clear_multi got=%b/%0d exp=1/1", cf1, cnt1); end
    @(negedge clk); clear_err = 1'b0; enable = 4'b0000;
    repeat (2) edge_sample();
    checks++; if (cf1 !== 1'b1 || cnt1 !== 8'd1) begin failures++; $display("FAIL clear_hold got=%b/%0d exp=1/1", cf1, cnt1); end
  endtask

  task automatic test_saturation();
    @(negedge clk); clear_err = 1'b1; enable = 4'b0011;
    edge_sample();
    @(negedge clk); clear_err = 1'b0;
    repeat (253) edge_sample();
    checks++; if (cnt1 !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", cnt1); end
    edge_sample();
    checks++; if (cnt1 !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", cnt1); end
    repeat (46) edge_sample();
    checks++; if (cnt0 !== 8'd255 || cf0 !== 1'b1) begin failures++; $display("FAIL sat_hold got=%0d/%b exp=255/1", cnt0, cf0); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); clear_err = 1'b1; enable = 4'b0011;
    edge_sample();
    @(negedge clk); clear_err = 1'b0;
    repeat (6) edge_sample();
    checks++; if (cnt1 !== 8'd7) begin failures++; $display("FAIL arst_pre got=%0d exp=7", cnt1); end
    @(negedge clk); rst_n = 1'b0; enable = 4'b0110; in_v[16 +: 16] = 16'hA5A5;
    #1;
    checks++; if (cnt1 !== 8'd0 || cf1 !== 1'b0 || own1 !== 2'd0) begin failures++; $display("FAIL arst_regs got=%0d/%b/%0d exp=0/0/0", cnt1, cf1, own1); end
    checks++; if (drv1 !== 1'b1 || out1 !== 16'hA5A5) begin failures++; $display("FAIL arst_comb got=%b/%h exp=1/a5a5", drv1, out1); end
    edge_sample();
    checks++; if (cnt1 !== 8'd0) begin failures++; $display("FAIL arst_held got=%0d exp=0", cnt1); end
    @(negedge clk); rst_n = 1'b1;
    edge_sample();
    checks++; if (cnt1 !== 8'd1 || cf1 !== 1'b1 || own1 !== 2'd1) begin failures++; $display("FAIL arst_release got=%0d/%b/%0d exp=1/1/1", cnt1, cf1, own1); end
  endtask

  initial begin
    test_reset();
    test_single_drive();
    test_keeper();
    test_priority_conflict();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
